// File: rtl/nrzi_decoder.sv
// NRZI line decoder: recovers bits (no transition = 1), removes stuffed zeros
// after STUFF_LEN ones and packs data bits into WIDTH-bit words.
module nrzi_decoder #(
  parameter int WIDTH     = 8,
  parameter int STUFF_LEN = 6,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_en,
  input  logic             line_in,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic             stuff_error
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(STUFF_LEN + 2);

  logic             prev_line;
  logic [CW-1:0]    ones_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_q;

  logic             d;
  logic             at_limit;
  logic             sample;
  logic             data_bit;
  logic             violation;
  logic             word_done;
  logic             drain;
  logic             load;
  logic [WIDTH-1:0] shift_next;

  // Output handshake: a word transfers on any clock edge where word_valid and
  // word_ready are both high; word_out is held stable while valid and not ready,
  // and a word completing on the transfer edge replaces the drained one.
  always_comb begin
    d          = ~(line_in ^ prev_line);
    at_limit   = (STUFF_LEN > 0) && (ones_cnt == CW'(STUFF_LEN));
    sample     = rx_en && !clear;
    data_bit   = sample && !at_limit;
    violation  = sample && at_limit && d;
    if (MSB_FIRST) shift_next = {shift_q[WIDTH-2:0], d};
    else           shift_next = {d, shift_q[WIDTH-1:1]};
    word_done  = data_bit && (bit_cnt == BW'(WIDTH - 1));
    drain      = word_valid && word_ready;
    load       = word_done && (!word_valid || word_ready);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_line   <= 1'b1;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      overflow    <= 1'b0;
      stuff_error <= 1'b0;
    end else begin
      stuff_error <= violation;

      if (load) begin
        word_out   <= shift_next;
        word_valid <= 1'b1;
      end else if (drain) begin
        word_valid <= 1'b0;
      end

      // clear only realigns the bit stream; the held word keeps its handshake
      if (clear) begin
        prev_line <= 1'b1;
        ones_cnt  <= '0;
        bit_cnt   <= '0;
        shift_q   <= '0;
        overflow  <= 1'b0;
      end else if (rx_en) begin
        prev_line <= line_in;
        if (data_bit) begin
          shift_q <= shift_next;
          bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
          if (STUFF_LEN > 0) ones_cnt <= d ? ones_cnt + CW'(1) : '0;
          if (word_done && !load) overflow <= 1'b1;
        end else begin
          ones_cnt <= '0;
          if (violation) bit_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nrzi_decoder.sv
// Bench for nrzi_decoder: LSB-first and MSB-first instances share stimulus;
// expected words are queued when driven and popped on each handshake.
module tb_nrzi_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_en;
  logic       line_in;
  logic       clear;
  logic       word_ready;
  logic [7:0] word_out, word_out_m;
  logic       word_valid, word_valid_m;
  logic       overflow, overflow_m;
  logic       stuff_error, stuff_error_m;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_m_q[$];

  typedef struct {
    logic [15:0] line;
    int          n;
    logic [7:0]  lsb;
    logic [7:0]  msb;
  } vec_t;
  vec_t vecs[5];

  nrzi_decoder #(.WIDTH(8), .STUFF_LEN(6), .MSB_FIRST(1'b0)) dut (
    .clock(clock), .reset(reset), .rx_en(rx_en), .line_in(line_in), .clear(clear),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .stuff_error(stuff_error)
  );

  nrzi_decoder #(.WIDTH(8), .STUFF_LEN(6), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .rx_en(rx_en), .line_in(line_in), .clear(clear),
    .word_out(word_out_m), .word_valid(word_valid_m), .word_ready(word_ready),
    .overflow(overflow_m), .stuff_error(stuff_error_m)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic sample(input logic l);
    rx_en = 1'b1;
    line_in = l;
    @(posedge clock); #1;
    rx_en = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input bit gaps);
    for (int k = 0; k < v.n; k++) begin
      sample(v.line[k]);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          line_in = 1'($urandom_range(0, 1));
          @(posedge clock); #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_m_q.size() != 0); i++)
      @(posedge clock);
    #1;
    chk("drain_lsb", exp_q.size(), 0);
    chk("drain_msb", exp_m_q.size(), 0);
  endtask

  // scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (stuff_error) err_cnt++;
      if (word_valid && word_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL word_lsb unexpected got=%0h want=none", word_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (word_out !== e) begin
            bad++;
            $display("FAIL word_lsb got=%0h want=%0h", word_out, e);
          end
        end
      end
      if (word_valid_m && word_ready) begin
        total++;
        if (exp_m_q.size() == 0) begin
          bad++;
          $display("FAIL word_msb unexpected got=%0h want=none", word_out_m);
        end else begin
          logic [7:0] e;
          e = exp_m_q.pop_front();
          if (word_out_m !== e) begin
            bad++;
            $display("FAIL word_msb got=%0h want=%0h", word_out_m, e);
          end
        end
      end
    end
  end

  initial begin
    vecs[0] = '{line: 16'h00AA, n: 8, lsb: 8'h00, msb: 8'h00};
    vecs[1] = '{line: 16'h00C9, n: 8, lsb: 8'hA5, msb: 8'hA5};
    vecs[2] = '{line: 16'h01BF, n: 9, lsb: 8'hBF, msb: 8'hFD};
    vecs[3] = '{line: 16'h0055, n: 8, lsb: 8'h01, msb: 8'h80};
    vecs[4] = '{line: 16'h001B, n: 8, lsb: 8'hD3, msb: 8'hCB};

    reset = 1'b1; rx_en = 1'b0; line_in = 1'b1; clear = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", stuff_error, 0);
    word_ready = 1'b1;

    // all transitions -> 0x00, one-cycle latency
    exp_q.push_back(8'h00); exp_m_q.push_back(8'h00);
    for (int k = 0; k < 8; k++) begin
      sample(vecs[0].line[k]);
      if (k == 6) chk("t1_valid_early", word_valid, 0);
    end
    chk("t1_valid", word_valid, 1);
    chk("t1_word", word_out, 8'h00);
    chk("t1_err", stuff_error, 0);
    wait_drain();

    // 0xA5 held under backpressure, then one-cycle consume
    clear_pulse();
    word_ready = 1'b0;
    exp_q.push_back(8'hA5); exp_m_q.push_back(8'hA5);
    send_vec(vecs[1], 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_word", word_out, 8'hA5);
      chk("t2_hold_valid", word_valid, 1);
      @(posedge clock); #1;
    end
    word_ready = 1'b1;
    @(posedge clock); #1;
    word_ready = 1'b0;
    chk("t2_consumed", word_valid, 0);
    chk("t2_q", exp_q.size(), 0);
    word_ready = 1'b1;

    // stuffed zero is not counted
    clear_pulse();
    exp_q.push_back(8'hBF); exp_m_q.push_back(8'hFD);
    for (int k = 0; k < 9; k++) begin
      sample(vecs[2].line[k]);
      if (k == 7) chk("t3_valid_early", word_valid, 0);
    end
    chk("t3_word", word_out, 8'hBF);
    chk("t3_word_m", word_out_m, 8'hFD);
    wait_drain();

    // stuff violation, then realigned 0xA5 without clear
    clear_pulse();
    for (int k = 0; k < 7; k++) sample(1'b1);
    chk("t4_err", stuff_error, 1);
    chk("t4_err_m", stuff_error_m, 1);
    @(posedge clock); #1;
    chk("t4_err_pulse", stuff_error, 0);
    chk("t4_noword", word_valid, 0);
    exp_q.push_back(8'hA5); exp_m_q.push_back(8'hA5);
    send_vec(vecs[1], 1'b0);
    wait_drain();

    // overflow, clear keeps held word, then simultaneous drain and load
    clear_pulse();
    word_ready = 1'b0;
    exp_q.push_back(8'hA5); exp_m_q.push_back(8'hA5);
    send_vec(vecs[1], 1'b0);
    send_vec(vecs[0], 1'b0);
    chk("t5_ovf", overflow, 1);
    chk("t5_keep", word_out, 8'hA5);
    clear_pulse();
    chk("t5_ovf_clr", overflow, 0);
    chk("t5_keep_clr", word_out, 8'hA5);
    chk("t5_valid_clr", word_valid, 1);
    exp_q.push_back(8'h00); exp_m_q.push_back(8'h00);
    for (int k = 0; k < 7; k++) sample(vecs[0].line[k]);
    word_ready = 1'b1;
    sample(vecs[0].line[7]);
    chk("t5_swap_valid", word_valid, 1);
    chk("t5_swap_word", word_out, 8'h00);
    chk("t5_swap_ovf", overflow, 0);
    wait_drain();

    // reset mid-word leaves no residue
    clear_pulse();
    sample(1'b1); sample(1'b0); sample(1'b1); sample(1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t6_rst_valid", word_valid, 0);
    chk("t6_rst_word", word_out_m, 0);
    exp_q.push_back(8'hA5); exp_m_q.push_back(8'hA5);
    send_vec(vecs[1], 1'b0);
    wait_drain();
    exp_q.push_back(vecs[4].lsb); exp_m_q.push_back(vecs[4].msb);
    send_vec(vecs[4], 1'b0);
    wait_drain();

    // table pass with random idle gaps between samples
    for (int i = 0; i < 5; i++) begin
      clear_pulse();
      exp_q.push_back(vecs[i].lsb); exp_m_q.push_back(vecs[i].msb);
      send_vec(vecs[i], 1'b1);
      wait_drain();
    end

    chk("err_count", err_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nrzi_decoder.md
Name: nrzi_decoder

Overview:
Receive-side counterpart of the team's NRZI encoder. Samples an NRZI line on sample strobes and recovers data bits: no transition = 1, transition = 0. Removes stuffed zeros after a run of ones and deserialises the bits into WIDTH-bit words. Words are presented on a valid/ready output with a one-entry holding register. Sits between the line sampler and the word-level packet logic.

Parameters:
WIDTH, 8, bits per output word (2..32)
STUFF_LEN, 6, ones-run length after which a stuffed 0 is expected; 0 disables unstuffing and error checking
MSB_FIRST, 0, 0: first received data bit lands in word bit 0; 1: first bit lands in bit WIDTH-1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
rx_en  input  1  sample strobe; line_in is consumed only on cycles with rx_en=1
line_in  input  1  NRZI line level
clear  input  1  synchronous resynchronise; restarts bit alignment
word_out  output  WIDTH  deserialised data word
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word_out when word_valid=1
overflow  output  1  sticky: a completed word was dropped
stuff_error  output  1  one-cycle pulse: ones run exceeded STUFF_LEN

Behaviour:
- Reset (async): prev_line=1; ones_cnt=0; bit_cnt=0; shift register=0; word_out=0; word_valid=0; overflow=0; stuff_error=0.
- prev_line=1 at reset matches the encoder's idle level. The first decoded bit equals line_in.
- Decode on rx_en=1 cycles: d = ~(line_in ^ prev_line); prev_line <= line_in. No state changes on rx_en=0 cycles, except for the output handshake.
- Unstuffing (STUFF_LEN>0):
  - ones_cnt<STUFF_LEN: d is a data bit. ones_cnt increments on d=1 and clears on d=0.
  - ones_cnt==STUFF_LEN and d=0: stuffed bit. Discard it, clear ones_cnt, leave bit_cnt unchanged.
  - ones_cnt==STUFF_LEN and d=1: stuff violation. Pulse stuff_error on the next cycle, discard the bit, discard the partial word (bit_cnt=0), clear ones_cnt.
- With STUFF_LEN=0, every decoded bit is data.
- Deserialise: each data bit is shifted in according to MSB_FIRST, and bit_cnt increments.
- Word completion: on the data bit that makes bit_cnt reach WIDTH, bit_cnt wraps to 0 and the word is offered to the holding register.
  - Holding register empty, or being drained this cycle (word_valid & word_ready): load word_out; word_valid=1 on the next cycle. Latency is 1 clock after the completing rx_en cycle.
  - Otherwise: drop the new word, set overflow=1, keep word_out and word_valid unchanged.
- Handshake:
  - word_valid & word_ready consumes the word. word_valid drops next cycle unless a new word loads in the same cycle; simultaneous consume and load keeps word_valid=1 with the new data.
  - word_out is stable while word_valid=1 and word_ready=0.
  - word_ready with word_valid=0 is ignored.
- clear (sync) has priority over rx_en. It sets prev_line=1, ones_cnt=0, bit_cnt=0, overflow=0, and discards the partial word. It does not affect a word already held in word_out/word_valid; the handshake continues in that cycle.
- Reset mid-word or mid-handshake: all state returns to reset values immediately; the held word is lost.

Test Plan:
1. STUFF_LEN=6. After reset, drive line 0,1,0,1,0,1,0,1 on consecutive rx_en cycles -> word_out=0x00, word_valid=1 one cycle after the 8th sample, stuff_error stays 0.
2. STUFF_LEN=6, MSB_FIRST=0. Drive line 1,0,0,1,0,0,1,1 (bits 1,0,1,0,0,1,0,1) -> word_out=0xA5. Hold word_ready=0 for 5 cycles: value stable. Raise word_ready for 1 cycle: word_valid=0 next cycle.
3. STUFF_LEN=6. Drive line 1,1,1,1,1,1,0,1,1 (six 1s, stuffed 0, data 0,1) -> word_out=0xBF after the 9th sample. The stuffed bit is not counted.
4. STUFF_LEN=6. Drive line 1 for 7 samples -> stuff_error=1 for exactly one cycle after the 7th sample, no word. Then send 0xA5 as in test 2, starting from line level 1 -> word_out=0xA5.
5. word_ready=0, two complete words 0xA5 then 0x00 -> word_out=0xA5, overflow=1 after the second word. Pulse clear -> overflow=0, word_out still 0xA5. Raise word_ready -> consumed.
6. Send 4 bits of a word, assert reset for 1 cycle, then send a full 0xA5 -> word_out=0xA5 with no residue from the partial word. Repeat with MSB_FIRST=1 and bits 1,0,1,0,0,1,0,1 -> 0xA5.
